riscram_ctrl: RTL

Parametrised single-port data memory controller for the single-cycle/multi-cycle MIPS32 datapath, replacing the fixed byte-lane RAM. It adds a Req/Ready handshake with registered read data, sign- or zero-extended sub-word loads, misalignment detection with an error counter, and a depth set by parameter. It sits between the CPU load/store unit and internal byte-lane storage: four 8-bit banks of 2^(ADDR_WIDTH-2) entries each.

---
 rtl/riscram_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/riscram_ctrl.sv
// Single-port byte-lane data memory controller for the MIPS32 load/store unit.
// Req/Ready handshake, registered sub-word load formatting, misalignment error tracking.
module riscram_ctrl #(
  parameter int ADDR_WIDTH   = 9,
  parameter int ERRCNT_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic                    Req,
  output logic                    Ready,
  input  logic                    RWn,
  input  logic [ADDR_WIDTH-1:0]   Addr,
  input  logic [2:0]              Mode,
  input  logic [31:0]             Din,
  output logic [31:0]             Dout,
  output logic                    DoutValid,
  output logic                    Err,
  output logic [ERRCNT_WIDTH-1:0] ErrCnt,
  output logic [1:0]              DbgState
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IW;

  // Handshake: a request transfers on a rising edge where Req && Ready;
  // Req must be held with stable RWn/Addr/Mode/Din until that edge.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0][7:0]         mem_q [DEPTH];
  logic [IW-1:0]           ridx_q, ridx_d;
  logic [1:0]              roff_q, roff_d;
  logic [2:0]              rmode_q, rmode_d;
  logic [31:0]             dout_q, dout_d;
  logic                    dvalid_q, dvalid_d;
  logic                    err_q, err_d;
  logic [ERRCNT_WIDTH-1:0] errcnt_q, errcnt_d;

  logic          accept;
  logic          aligned;
  logic          is_word;
  logic          is_half;
  logic          wr_en;
  logic [3:0]    lane_we;
  logic [31:0]   lane_wdata;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   rd_fmt;

  assign Ready    = (state_q != ST_RD);
  assign accept   = Req && Ready;
  assign is_word  = (Mode[1:0] == 2'b00) || (Mode[1:0] == 2'b11);
  assign is_half  = (Mode[1:0] == 2'b10);
  assign aligned  = is_word ? (Addr[1:0] == 2'b00) :
                    is_half ? (Addr[0] == 1'b0) : 1'b1;
  assign wr_en    = RSTn && accept && !RWn && aligned;

  // Lane data is replicated so each enabled lane picks its own slice.
  always_comb begin
    lane_we    = 4'b0000;
    lane_wdata = Din;
    if (is_word) begin
      lane_we = 4'b1111;
    end else if (is_half) begin
      lane_we    = Addr[1] ? 4'b1100 : 4'b0011;
      lane_wdata = {2{Din[15:0]}};
    end else begin
      lane_we    = 4'b0001 << Addr[1:0];
      lane_wdata = {4{Din[7:0]}};
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      for (int l = 0; l < 4; l++) begin
        if (lane_we[l]) mem_q[Addr[ADDR_WIDTH-1:2]][l] <= lane_wdata[l*8 +: 8];
      end
    end
  end

  assign rd_word = mem_q[ridx_q];
  assign rd_byte = rd_word[{roff_q, 3'b000} +: 8];
  assign rd_half = roff_q[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    rd_fmt = rd_word;
    if (rmode_q[1:0] == 2'b01) begin
      rd_fmt = {{24{rmode_q[2] & rd_byte[7]}}, rd_byte};
    end else if (rmode_q[1:0] == 2'b10) begin
      rd_fmt = {{16{rmode_q[2] & rd_half[15]}}, rd_half};
    end
  end

  always_comb begin
    state_d  = ST_IDLE;
    ridx_d   = ridx_q;
    roff_d   = roff_q;
    rmode_d  = rmode_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    err_d    = 1'b0;
    errcnt_d = errcnt_q;
    case (state_q)
      ST_RD: begin
        state_d  = ST_RESP;
        dout_d   = rd_fmt;
        dvalid_d = 1'b1;
      end
      default: begin
        if (accept) begin
          if (!aligned) begin
            err_d = 1'b1;
            if (errcnt_q != {ERRCNT_WIDTH{1'b1}}) errcnt_d = errcnt_q + 1'b1;
            if (RWn) begin
              state_d  = ST_RESP;
              dout_d   = 32'd0;
              dvalid_d = 1'b1;
            end
          end else if (RWn) begin
            state_d = ST_RD;
            ridx_d  = Addr[ADDR_WIDTH-1:2];
            roff_d  = Addr[1:0];
            rmode_d = Mode;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q  <= ST_IDLE;
      ridx_q   <= '0;
      roff_q   <= 2'b00;
      rmode_q  <= 3'b000;
      dout_q   <= 32'd0;
      dvalid_q <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ridx_q   <= ridx_d;
      roff_q   <= roff_d;
      rmode_q  <= rmode_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign Dout      = dout_q;
  assign DoutValid = dvalid_q;
  assign Err       = err_q;
  assign ErrCnt    = errcnt_q;
  assign DbgState  = state_q;

endmodule
